clock_time_ctrl: RTL and testbench
==================================

# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. Consumes the one-cycle `tick_1s` strobe from the clock divider and two pre-debounced, single-cycle button pulses. Runs a mode state machine (run / set hours / set minutes) and owns the hours/minutes/seconds registers that drive the display path.

## Interface
- No parameters; the only build option is the `HOUR12_EN` macro (see Configuration).
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset asserted); released synchronously by the system.
- `tick_1s` input 1: one-cycle pulse, once per second, from the clock divider.
- `btn_mode` input 1: one-cycle pulse, debounced upstream; advances the mode.
- `btn_inc` input 1: one-cycle pulse, debounced upstream; increments the field being edited.
- `hours` output 5: current hour, binary.
- `minutes` output 6: current minute, binary 0..59.
- `seconds` output 6: current second, binary 0..59.
- `mode` output 2: 00 = RUN, 01 = SET_HR, 10 = SET_MIN; 11 is never driven.
- `blink` output 1: display-blank phase for the field being edited; always 0 in RUN.
- `pm` output 1: PM flag; valid only with `HOUR12_EN`, otherwise tied to 0.

## Operation
- State machine transitions, all on `btn_mode`:
  - RUN → SET_HR
  - SET_HR → SET_MIN
  - SET_MIN → RUN
  - The encoding is driven directly on `mode`.
- **RUN:**
  - Each `tick_1s` advances time by one second.
  - `seconds` 59→0 carries into `minutes`.
  - `minutes` 59→0 carries into `hours`.
  - `hours` wraps per the Configuration rules.
  - `btn_inc` is ignored.
- **SET_HR / SET_MIN:**
  - Time is frozen; `tick_1s` does not advance `seconds`.
  - `btn_inc` increments the selected field by one, with wrap.
  - Minute wrap does not carry into hours. Hour wrap follows the same rule as the RUN carry, including the `pm` toggle.
- Leaving SET_MIN for RUN clears `seconds` to 0 in the same edge.
- `blink` toggles on each `tick_1s` while in SET_HR or SET_MIN. It is forced to 0 on entry to SET_HR and on any transition into RUN. SET_HR → SET_MIN does not reset `blink`.
- **Simultaneous events:**
  - `btn_mode` + `btn_inc` in the same cycle: the mode change wins and `btn_inc` is dropped.
  - `tick_1s` + `btn_mode` in RUN: the tick is applied (time advances) and the state moves to SET_HR on the same edge.
  - `tick_1s` + `btn_inc` in a SET state: the increment is applied and `blink` toggles.
- Reset asserted at any time (mid-set or mid-carry) immediately forces all outputs to reset values.

## Timing
- All outputs are registered. Every response appears on the first rising edge that samples the stimulus high, i.e. one cycle of latency.
- A full carry chain (e.g. 23:59:59 → 00:00:00) completes in that single edge, with no intermediate values visible.
- Input pulses held high for N cycles act as N events; upstream guarantees single-cycle pulses.
- Reset values:
  - `mode` = 00, `blink` = 0, `minutes` = 0, `seconds` = 0, `pm` = 0.
  - `hours` = 0, or 12 with `HOUR12_EN`.

## Configuration
- Macro: `HOUR12_EN`.
- **Defined (12-hour operation):**
  - `hours` takes values 1..12 only.
  - The hour sequence is 11→12, which toggles `pm`, then 12→1, which does not toggle `pm`.
  - Reset is 12:00:00 with `pm` = 0 (midnight).
- **Undefined (24-hour operation):**
  - `hours` takes values 0..23, wrapping 23→0.
  - `pm` is constant 0.

## Test plan
- Reset mid-count: drive time to 05:17:42, assert `rst` = 0 asynchronously → outputs are 00:00:00 (12:00:00 with `HOUR12_EN`), `mode` = 00, `blink` = 0, without waiting for a clock edge.
- Full rollover (24-hour build): preset 23:59:59, one `tick_1s` → 00:00:00 one cycle later. 12-hour build: 11:59:59 with `pm` = 0 plus one tick → 12:00:00 with `pm` = 1.
- Set sequence from 10:20:35: `btn_mode`, then `btn_inc` ×15 → `hours` = 1 (24-hour build, wrap via 23→0). Then `btn_mode`, `btn_inc` ×45 → `minutes` = 5 (59→0, no hour carry). Then `btn_mode` → `mode` = 00, time 01:05:00.
- Frozen time: in SET_MIN, apply 3 `tick_1s` → `seconds` unchanged and `blink` sequence 1, 0, 1. Then `btn_mode` → `blink` = 0.
- Collisions:
  - `btn_mode` + `btn_inc` together in SET_HR → `mode` = 10 and `hours` unchanged.
  - `tick_1s` + `btn_mode` in RUN at 00:00:59 → 00:01:00 with `mode` = 01.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - clock mode FSM and h:m:s time registers; HOUR12_EN selects 12-hour operation
module clock_time_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

`ifdef HOUR12_EN
    localparam logic [4:0] HOUR_RST = 5'd12;
`else
    localparam logic [4:0] HOUR_RST = 5'd0;
`endif

    logic [4:0] hour_next;
    logic       pm_flip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (btn_mode) begin
            case (state)
                RUN:     state_nxt = SET_HR;
                SET_HR:  state_nxt = SET_MIN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        mode = state;
    end

    // Shared by the RUN carry and the SET_HR increment so both wrap identically.
    always_comb begin
`ifdef HOUR12_EN
        hour_next = (hours == 5'd12) ? 5'd1 : hours + 5'd1;
        pm_flip   = (hours == 5'd11);
`else
        hour_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        pm_flip   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hours   <= HOUR_RST;
            minutes <= 6'd0;
            seconds <= 6'd0;
            blink   <= 1'b0;
            pm      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    blink <= 1'b0;
                    if (tick_1s) begin
                        if (seconds == 6'd59) begin
                            seconds <= 6'd0;
                            if (minutes == 6'd59) begin
                                minutes <= 6'd0;
                                hours   <= hour_next;
                                pm      <= pm ^ pm_flip;
                            end else begin
                                minutes <= minutes + 6'd1;
                            end
                        end else begin
                            seconds <= seconds + 6'd1;
                        end
                    end
                end
                SET_HR, SET_MIN: begin
                    if (btn_mode && state == SET_MIN) begin
                        blink   <= 1'b0;
                        seconds <= 6'd0;
                    end else if (tick_1s) begin
                        blink <= ~blink;
                    end
                    // A mode press in the same cycle swallows the increment.
                    if (btn_inc && !btn_mode) begin
                        if (state == SET_HR) begin
                            hours <= hour_next;
                            pm    <= pm ^ pm_flip;
                        end else begin
                            minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                        end
                    end
                end
                default: begin
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - scoreboard bench for clock_time_ctrl against a seconds-of-day model
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1s = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       pm;

    clock_time_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1s  (tick_1s),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .blink    (blink),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int mi;
        int s;
        int md;
        int bl;
        int pm;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: time of day as 24-hour fields, mode as 0/1/2.
    int m_h, m_m, m_s, m_mode, m_blink;

    function automatic exp_t model_view();
        exp_t e;
`ifdef HOUR12_EN
        e.h  = (m_h % 12 == 0) ? 12 : m_h % 12;
        e.pm = (m_h >= 12) ? 1 : 0;
`else
        e.h  = m_h;
        e.pm = 0;
`endif
        e.mi = m_m;
        e.s  = m_s;
        e.md = m_mode;
        e.bl = m_blink;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".hours"},   int'(hours),   e.h);
        check({tag, ".minutes"}, int'(minutes), e.mi);
        check({tag, ".seconds"}, int'(seconds), e.s);
        check({tag, ".mode"},    int'(mode),    e.md);
        check({tag, ".blink"},   int'(blink),   e.bl);
        check({tag, ".pm"},      int'(pm),      e.pm);
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0;
    endtask

    task automatic model_step(input bit t, input bit b_mode, input bit b_inc);
        int tod;
        if (m_mode == 0) begin
            if (t) begin
                tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                m_s = tod % 60;
            end
            if (b_mode) begin
                m_mode  = 1;
                m_blink = 0;
            end
        end else begin
            if (t) m_blink = 1 - m_blink;
            if (b_mode) begin
                if (m_mode == 1) begin
                    m_mode = 2;
                end else begin
                    m_mode  = 0;
                    m_blink = 0;
                    m_s     = 0;
                end
            end else if (b_inc) begin
                if (m_mode == 1) m_h = (m_h + 1) % 24;
                else             m_m = (m_m + 1) % 60;
            end
        end
    endtask

    task automatic step(input bit t, input bit b_mode, input bit b_inc);
        @(negedge clk);
        tick_1s  = t;
        btn_mode = b_mode;
        btn_inc  = b_inc;
        model_step(t, b_mode, b_inc);
        exp_q.push_back(model_view());
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        while (m_mode != 0) step(0, 1, 0);
        step(0, 1, 0);
        while (m_h != h) step(0, 0, 1);
        step(0, 1, 0);
        while (m_m != mi) step(0, 0, 1);
        step(0, 1, 0);
        repeat (s) step(1, 0, 0);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        tick_1s = 0; btn_mode = 0; btn_inc = 0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag, model_view());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("sb", e);
            end
        end
    end

    initial begin : driver
        model_reset();
        #1;
        check_all("reset_init", model_view());
        @(negedge clk);
        rst = 1'b1;

        set_time(5, 17, 42);
        async_reset_check("reset_mid");

        set_time(23, 59, 59);
        step(1, 0, 0);
        step(0, 0, 0);

        set_time(11, 59, 59);
        step(1, 0, 0);
        step(0, 0, 0);

        set_time(10, 20, 35);
        step(0, 1, 0);
        repeat (15) step(0, 0, 1);
        step(0, 1, 0);
        repeat (45) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);

        step(0, 1, 0);
        step(0, 1, 1);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);

        step(0, 1, 0);
        step(0, 1, 1);
        step(1, 0, 1);
        step(0, 1, 0);

        set_time(0, 0, 59);
        step(1, 1, 0);
        step(0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 3) == 0);
        end
        step(0, 0, 0);
        async_reset_check("reset_end");

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
